mskaes_128bits_round_ctrl: RTL and testbench

Control unit that sequences the masked AES-128 encryption round datapath (d-share state register, pipelined masked S-box layer, ShiftRows, MixColumns, AddRoundKey). It accepts one encryption job through a valid/ready handshake and drives the datapath strobes for the initial key addition and 10 rounds. It supplies the round constant and the fresh-randomness request to the key schedule and the randomness source, and holds the result until the consumer takes it. It carries no share data; it is share-count agnostic apart from the `d` pass-through.

---
 rtl/mskaes_pkg.sv | 18 +
 rtl/mskaes_rcon_gen.sv | 23 ++
 rtl/mskaes_128bits_round_ctrl.sv | 131 +++++++++++++
 tb/tb_mskaes_128bits_round_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mskaes_pkg.sv
// Shared definitions for the masked AES-128 control slice.
package mskaes_pkg;

   localparam int         NROUNDS   = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } rc_state_e;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/mskaes_rcon_gen.sv
// Round-constant generator: init loads 01, each step doubles in GF(2^8).
module mskaes_rcon_gen
   import mskaes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       init,
   input  logic       step,
   output logic [7:0] rcon
);

   logic [7:0] rcon_q;

   // Constant register; init takes priority so a new job always restarts at 01.
   always_ff @(posedge clk) begin
      if (rst)       rcon_q <= 8'h00;
      else if (init) rcon_q <= RCON_INIT;
      else if (step) rcon_q <= xtime(rcon_q);
   end

   assign rcon = rcon_q;

endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Sequencer for the masked AES-128 round datapath: initial key add, 10 rounds,
// each round SBOX_LAT randomness cycles plus one capture cycle.
module mskaes_128bits_round_ctrl
   import mskaes_pkg::*;
#(
   parameter int d        = 2,
   parameter int SBOX_LAT = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       state_load,
   output logic       state_en,
   output logic       last_round,
   output logic       rnd_req,
   output logic [3:0] round_idx,
   output logic [7:0] rcon,
   output logic       busy
);

   localparam int            CW       = $clog2(SBOX_LAT + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(SBOX_LAT);
   localparam logic [3:0]    RND_LAST = 4'(NROUNDS);

   if (d < 2 || SBOX_LAT < 1) begin : g_bad_param
      $error("mskaes_128bits_round_ctrl: need d >= 2 and SBOX_LAT >= 1");
   end

   rc_state_e     state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          rcon_init, rcon_step;
   logic [7:0]    rcon_q;

   mskaes_rcon_gen u_rcon (
      .clk  (clk),
      .rst  (rst),
      .init (rcon_init),
      .step (rcon_step),
      .rcon (rcon_q)
   );

   // State, round and sub-cycle registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         cyc_q   <= cyc_d;
      end
   end

   // Next state and strobes; everything is held low while rst is high so the
   // datapath sees no strobe in the reset cycle itself.
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      cyc_d      = cyc_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      state_load = 1'b0;
      state_en   = 1'b0;
      last_round = 1'b0;
      rnd_req    = 1'b0;
      busy       = 1'b0;
      rcon_init  = 1'b0;
      rcon_step  = 1'b0;
      round_idx  = 4'd0;
      rcon       = 8'h00;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  state_load = 1'b1;
                  rcon_init  = 1'b1;
                  state_d    = ROUND;
                  round_d    = 4'd1;
                  cyc_d      = '0;
               end
            end
            ROUND: begin
               busy       = 1'b1;
               round_idx  = round_q;
               rcon       = rcon_q;
               last_round = (round_q == RND_LAST);
               if (cyc_q == CYC_LAST) begin
                  state_en = 1'b1;
                  cyc_d    = '0;
                  if (round_q == RND_LAST) begin
                     state_d = DONE;
                     round_d = 4'd0;
                  end else begin
                     round_d   = round_q + 4'd1;
                     rcon_step = 1'b1;
                  end
               end else begin
                  rnd_req = 1'b1;
                  cyc_d   = cyc_q + 1'b1;
               end
            end
            DONE: begin
               busy      = 1'b1;
               out_valid = 1'b1;
               in_ready  = out_ready;
               if (out_ready) begin
                  if (in_valid) begin
                     // Back-to-back: the consumer's take frees the state register
                     // in the same cycle the next job is loaded.
                     state_load = 1'b1;
                     rcon_init  = 1'b1;
                     state_d    = ROUND;
                     round_d    = 4'd1;
                     cyc_d      = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Directed bench: default SBOX_LAT=4 instance plus an SBOX_LAT=1 instance.
module tb_mskaes_128bits_round_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: SBOX_LAT=4
   logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic       a_in_ready, a_out_valid, a_state_load, a_state_en, a_last_round, a_rnd_req, a_busy;
   logic [3:0] a_round_idx;
   logic [7:0] a_rcon;

   mskaes_128bits_round_ctrl #(.d(2), .SBOX_LAT(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .state_load(a_state_load),
      .state_en(a_state_en), .last_round(a_last_round), .rnd_req(a_rnd_req),
      .round_idx(a_round_idx), .rcon(a_rcon), .busy(a_busy)
   );

   // Instance B: SBOX_LAT=1
   logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic       b_in_ready, b_out_valid, b_state_load, b_state_en, b_last_round, b_rnd_req, b_busy;
   logic [3:0] b_round_idx;
   logic [7:0] b_rcon;

   mskaes_128bits_round_ctrl #(.d(2), .SBOX_LAT(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .state_load(b_state_load),
      .state_en(b_state_en), .last_round(b_last_round), .rnd_req(b_rnd_req),
      .round_idx(b_round_idx), .rcon(b_rcon), .busy(b_busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Cycle counter and per-instance event monitors (sampled mid-cycle).
   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   int         a_t_acc = 0, a_en_cnt = 0, a_rnd_cnt = 0, a_ov_cnt = 0;
   int         a_en_off [16];
   logic [7:0] a_rcon_at [16];
   logic       a_lr_at [16];
   int         b_t_acc = 0, b_en_cnt = 0, b_rnd_cnt = 0;

   always @(negedge clk) begin
      if (a_state_load) a_t_acc = cnt;
      if (a_state_en) begin
         if (a_en_cnt < 16) a_en_off[a_en_cnt] = cnt - a_t_acc;
         a_rcon_at[a_round_idx] = a_rcon;
         a_lr_at[a_round_idx]   = a_last_round;
         a_en_cnt++;
      end
      if (a_rnd_req)   a_rnd_cnt++;
      if (a_out_valid) a_ov_cnt++;
      if (b_state_load) b_t_acc = cnt;
      if (b_state_en)   b_en_cnt++;
      if (b_rnd_req)    b_rnd_cnt++;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic wait_ov(input bit sel_b, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         sample();
         if (sel_b ? b_out_valid : a_out_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   function automatic logic [18:0] a_outs();
      return {a_in_ready, a_out_valid, a_state_load, a_state_en, a_last_round,
              a_rnd_req, a_round_idx, a_rcon, a_busy};
   endfunction

   logic [7:0] exp_rcon [10];
   bit         ok;

   initial begin
      exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

      // Reset: everything low, including in_ready, even with in_valid offered.
      a_in_valid = 1'b1;
      repeat (3) step();
      sample();
      chk("rst_outs_a", 32'(a_outs()), 32'd0);
      chk("rst_ready_b", 32'(b_in_ready), 32'd0);
      step();
      rst = 1'b0; a_in_valid = 1'b0;
      sample();
      chk("ready_after_rst", 32'({a_in_ready, a_busy, a_out_valid}), 32'b100);

      // Job 1: out_ready high throughout.
      step();
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      a_en_cnt = 0; a_rnd_cnt = 0;
      sample();
      chk("job1_load", 32'(a_state_load), 32'd1);
      step();
      a_in_valid = 1'b0;
      sample();
      chk("r1_idx_rcon", 32'({a_round_idx, a_rcon, a_busy, a_in_ready}), 32'({4'd1, 8'h01, 1'b1, 1'b0}));
      wait_ov(1'b0, 80, ok);
      chk("job1_ov_seen", 32'(ok), 32'd1);
      chk("job1_latency", 32'(cnt - a_t_acc), 32'd51);
      chk("job1_en_cnt", 32'(a_en_cnt), 32'd10);
      chk("job1_rnd_cnt", 32'(a_rnd_cnt), 32'd40);
      for (int r = 0; r < 10; r++) begin
         chk($sformatf("en_off_%0d", r + 1), 32'(a_en_off[r]), 32'(5 * (r + 1)));
         chk($sformatf("rcon_r%0d", r + 1), 32'(a_rcon_at[r + 1]), 32'(exp_rcon[r]));
         chk($sformatf("last_r%0d", r + 1), 32'(a_lr_at[r + 1]), 32'(r == 9));
      end
      step();
      sample();
      chk("job1_back_idle", 32'({a_in_ready, a_busy, a_out_valid}), 32'b100);

      // Job 2: consumer stalls 7 cycles in DONE.
      step();
      a_in_valid = 1'b1; a_out_ready = 1'b0;
      step();
      a_in_valid = 1'b0;
      wait_ov(1'b0, 80, ok);
      chk("job2_ov_seen", 32'(ok), 32'd1);
      chk("done_idx_rcon", 32'({a_round_idx, a_rcon, a_last_round}), 32'd0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("hold_%0d", i), 32'({a_out_valid, a_state_en, a_state_load, a_in_ready, a_busy}),
             32'b10001);
         step();
         sample();
      end
      step();
      a_out_ready = 1'b1;
      sample();
      chk("release_ready", 32'({a_in_ready, a_out_valid}), 32'b11);
      step();
      a_out_ready = 1'b0;
      sample();
      chk("release_idle", 32'({a_in_ready, a_busy, a_out_valid}), 32'b100);

      // Job 3 then back-to-back job 4 accepted in the DONE/out_ready cycle.
      step();
      a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      wait_ov(1'b0, 80, ok);
      chk("job3_ov_seen", 32'(ok), 32'd1);
      step();
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      a_en_cnt = 0;
      sample();
      chk("b2b_load", 32'({a_state_load, a_in_ready, a_out_valid}), 32'b111);
      step();
      a_in_valid = 1'b0;
      sample();
      chk("b2b_round1", 32'({a_round_idx, a_rcon}), 32'({4'd1, 8'h01}));
      wait_ov(1'b0, 80, ok);
      chk("b2b_ov_seen", 32'(ok), 32'd1);
      chk("b2b_latency", 32'(cnt - a_t_acc), 32'd51);
      chk("b2b_en_cnt", 32'(a_en_cnt), 32'd10);
      step();

      // Job 5: abort with rst at round 6, cyc 2.
      step();
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      step();
      a_in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         sample();
         if (a_round_idx == 4'd6) ok = 1'b1;
      end
      chk("abort_reach_r6", 32'(ok), 32'd1);
      chk("abort_r6_rcon", 32'({a_rcon, a_rnd_req}), 32'({8'h20, 1'b1}));
      a_ov_cnt = 0;
      step();
      step();
      rst = 1'b1;
      sample();
      chk("abort_rst_outs", 32'(a_outs()), 32'd0);
      step();
      rst = 1'b0;
      sample();
      chk("abort_idle", 32'(a_outs()), 32'({1'b1, 18'd0}));
      repeat (60) step();
      chk("abort_no_ov", 32'(a_ov_cnt), 32'd0);

      // SBOX_LAT=1 instance.
      b_in_valid = 1'b1; b_out_ready = 1'b1;
      b_en_cnt = 0; b_rnd_cnt = 0;
      step();
      b_in_valid = 1'b0;
      wait_ov(1'b1, 40, ok);
      chk("b_ov_seen", 32'(ok), 32'd1);
      chk("b_latency", 32'(cnt - b_t_acc), 32'd21);
      chk("b_rnd_cnt", 32'(b_rnd_cnt), 32'd10);
      chk("b_en_cnt", 32'(b_en_cnt), 32'd10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
